bsg_manycore_request_initiator: RTL and testbench

//  Master-side initiator driving an endpoint's out_request and in_response groups.
//  - Accepts simple load/store commands and builds manycore request packets.
//  - Allocates a 5-bit reg_id tag per request and tracks outstanding requests.
//  - Retires store credits internally; presents load data as tagged responses.

---
 rtl/bsg_manycore_request_initiator.sv | 203 ++++++++++++++++++++
 tb/tb_bsg_manycore_request_initiator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_request_initiator.sv
// Tagged remote load/store initiator: builds manycore request packets, tracks reg_id tags,
// retires store credits and returns load data. Define BSG_MANYCORE_INITIATOR_STATS_EN for traffic counters.
module bsg_manycore_request_initiator #(
   parameter int x_cord_width_p = 4,
   parameter int y_cord_width_p = 4,
   parameter int addr_width_p   = 16,
   parameter int data_width_p   = 32,
   parameter int max_out_p      = 8,
   localparam int mask_width_lp   = data_width_p >> 3,
   localparam int packet_width_lp = addr_width_p + 2 + mask_width_lp + 5 + data_width_p
                                    + 2 * (x_cord_width_p + y_cord_width_p),
   localparam int count_width_lp  = $clog2(max_out_p + 1)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       cmd_v_i,
   input  logic                       cmd_we_i,
   input  logic [addr_width_p-1:0]    cmd_addr_i,
   input  logic [data_width_p-1:0]    cmd_data_i,
   input  logic [mask_width_lp-1:0]   cmd_mask_i,
   input  logic [x_cord_width_p-1:0]  cmd_x_i,
   input  logic [y_cord_width_p-1:0]  cmd_y_i,
   output logic                       cmd_ready_o,
   output logic                       out_v_o,
   output logic [packet_width_lp-1:0] out_packet_o,
   input  logic                       out_ready_i,
   input  logic                       returned_v_i,
   input  logic [data_width_p-1:0]    returned_data_i,
   input  logic [4:0]                 returned_reg_id_i,
   input  logic [1:0]                 returned_pkt_type_i,
   output logic                       returned_yumi_o,
   input  logic                       returned_credit_v_i,
   input  logic [4:0]                 returned_credit_reg_id_i,
   output logic                       resp_v_o,
   output logic [data_width_p-1:0]    resp_data_o,
   output logic [4:0]                 resp_tag_o,
   input  logic                       resp_yumi_i,
   input  logic                       fence_i,
   output logic                       fence_done_o,
   output logic [count_width_lp-1:0]  outstanding_o,
`ifdef BSG_MANYCORE_INITIATOR_STATS_EN
   output logic [31:0]                stat_loads_o,
   output logic [31:0]                stat_stores_o,
   output logic [31:0]                stat_stall_o,
`endif
   input  logic [x_cord_width_p-1:0]  my_x_i,
   input  logic [y_cord_width_p-1:0]  my_y_i
);

   typedef enum logic [1:0] {e_remote_load = 2'd0, e_remote_store = 2'd1} op_e;

   typedef struct packed {
      logic [addr_width_p-1:0]   addr;
      op_e                       op;
      logic [mask_width_lp-1:0]  op_ex;
      logic [4:0]                reg_id;
      logic [data_width_p-1:0]   payload;
      logic [y_cord_width_p-1:0] src_y_cord;
      logic [x_cord_width_p-1:0] src_x_cord;
      logic [y_cord_width_p-1:0] y_cord;
      logic [x_cord_width_p-1:0] x_cord;
   } packet_s;

   typedef enum logic {EMPTY, FULL} state_e;

   state_e                  state_q, state_d;
   packet_s                 pkt_q, pkt_d;
   logic [max_out_p-1:0]    busy_q, busy_d, set_vec, clr_vec;
   logic [31:0]             busy_ext;
   logic                    resp_v_q, resp_v_d;
   logic [data_width_p-1:0] resp_data_q;
   logic [4:0]              resp_tag_q;
   logic                    free_found;
   logic [4:0]              free_tag;
   logic                    accept, send, credit_ok, ret_ok;
   logic [count_width_lp-1:0] outstanding;
   logic                    unused_pkt_type;

   assign unused_pkt_type = ^returned_pkt_type_i;
   assign busy_ext        = 32'(busy_q);

   // Allocation looks only at registered busy bits, so a tag freed this cycle waits a cycle.
   always_comb begin
      free_found = 1'b0;
      free_tag   = '0;
      for (int i = max_out_p - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_found = 1'b1;
            free_tag   = 5'(i);
         end
      end
   end

   always_comb begin
      outstanding = '0;
      for (int i = 0; i < max_out_p; i++) begin
         outstanding = outstanding + count_width_lp'(busy_q[i]);
      end
   end

   assign out_v_o         = (state_q == FULL);
   assign send            = out_v_o & out_ready_i;
   assign cmd_ready_o     = ~fence_i & free_found & ((state_q == EMPTY) | out_ready_i);
   assign accept          = cmd_v_i & cmd_ready_o;
   assign returned_yumi_o = returned_v_i & (~resp_v_q | resp_yumi_i);
   // Returns/credits for idle tags are consumed but otherwise ignored.
   assign credit_ok       = returned_credit_v_i & busy_ext[returned_credit_reg_id_i];
   assign ret_ok          = returned_yumi_o & busy_ext[returned_reg_id_i];

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int i = 0; i < max_out_p; i++) begin
         if (accept && free_tag == 5'(i)) set_vec[i] = 1'b1;
         if ((credit_ok && returned_credit_reg_id_i == 5'(i)) ||
             (ret_ok && returned_reg_id_i == 5'(i))) clr_vec[i] = 1'b1;
      end
      busy_d = (busy_q & ~clr_vec) | set_vec;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (accept) state_d = FULL;
         FULL:    if (send && !accept) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      pkt_d = pkt_q;
      if (accept) begin
         pkt_d.addr       = cmd_addr_i;
         pkt_d.op         = cmd_we_i ? e_remote_store : e_remote_load;
         pkt_d.op_ex      = cmd_we_i ? cmd_mask_i : '0;
         pkt_d.reg_id     = free_tag;
         pkt_d.payload    = cmd_we_i ? cmd_data_i : '0;
         pkt_d.src_y_cord = my_y_i;
         pkt_d.src_x_cord = my_x_i;
         pkt_d.y_cord     = cmd_y_i;
         pkt_d.x_cord     = cmd_x_i;
      end
   end

   assign resp_v_d = ret_ok ? 1'b1 : (resp_yumi_i ? 1'b0 : resp_v_q);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= EMPTY;
         busy_q   <= '0;
         resp_v_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         resp_v_q <= resp_v_d;
      end
   end

   always_ff @(posedge clk_i) begin
      pkt_q <= pkt_d;
      if (ret_ok) begin
         resp_data_q <= returned_data_i;
         resp_tag_q  <= returned_reg_id_i;
      end
   end

   assign out_packet_o  = pkt_q;
   assign resp_v_o      = resp_v_q;
   assign resp_data_o   = resp_data_q;
   assign resp_tag_o    = resp_tag_q;
   assign outstanding_o = outstanding;
   assign fence_done_o  = fence_i & ~(|busy_q) & (state_q == EMPTY);

`ifdef BSG_MANYCORE_INITIATOR_STATS_EN
   logic [31:0] stat_loads_q, stat_stores_q, stat_stall_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         stat_loads_q  <= '0;
         stat_stores_q <= '0;
         stat_stall_q  <= '0;
      end else begin
         if (send && pkt_q.op == e_remote_load)  stat_loads_q  <= stat_loads_q + 32'd1;
         if (send && pkt_q.op == e_remote_store) stat_stores_q <= stat_stores_q + 32'd1;
         if (out_v_o && !out_ready_i)            stat_stall_q  <= stat_stall_q + 32'd1;
      end
   end

   assign stat_loads_o  = stat_loads_q;
   assign stat_stores_o = stat_stores_q;
   assign stat_stall_o  = stat_stall_q;
`endif

`ifndef SYNTHESIS
   assert property (@(posedge clk_i) disable iff (reset_i)
                    returned_credit_v_i |-> busy_ext[returned_credit_reg_id_i])
      else $error("store credit on idle reg_id %0d", returned_credit_reg_id_i);
   assert property (@(posedge clk_i) disable iff (reset_i)
                    returned_yumi_o |-> busy_ext[returned_reg_id_i])
      else $error("load return on idle reg_id %0d", returned_reg_id_i);
`endif

endmodule

// File: tb/tb_bsg_manycore_request_initiator.sv
// Scoreboard bench for bsg_manycore_request_initiator (default build, max_out_p = 8).
module tb_bsg_manycore_request_initiator;

   localparam int XW = 4, YW = 4, AW = 16, DW = 32, MO = 8;
   localparam int MW = DW >> 3;
   localparam int PW = AW + 2 + MW + 5 + DW + 2 * (XW + YW);
   localparam int CW = $clog2(MO + 1);

   logic clk = 1'b0;
   logic reset_i = 1'b1;
   logic cmd_v_i = 1'b0, cmd_we_i = 1'b0;
   logic [AW-1:0] cmd_addr_i = '0;
   logic [DW-1:0] cmd_data_i = '0;
   logic [MW-1:0] cmd_mask_i = '0;
   logic [XW-1:0] cmd_x_i = '0;
   logic [YW-1:0] cmd_y_i = '0;
   logic cmd_ready_o, out_v_o;
   logic [PW-1:0] out_packet_o;
   logic out_ready_i = 1'b1;
   logic returned_v_i = 1'b0;
   logic [DW-1:0] returned_data_i = '0;
   logic [4:0] returned_reg_id_i = '0;
   logic [1:0] returned_pkt_type_i = '0;
   logic returned_yumi_o;
   logic returned_credit_v_i = 1'b0;
   logic [4:0] returned_credit_reg_id_i = '0;
   logic resp_v_o;
   logic [DW-1:0] resp_data_o;
   logic [4:0] resp_tag_o;
   logic resp_yumi_i = 1'b1;
   logic fence_i = 1'b0;
   logic fence_done_o;
   logic [CW-1:0] outstanding_o;
   logic [XW-1:0] my_x_i = 4'hA;
   logic [YW-1:0] my_y_i = 4'h5;

   int n_checks = 0;
   int n_pass = 0;
   logic [PW-1:0] pkt_q[$];
   logic [36:0]   resp_q[$];

   always #5 clk = ~clk;

   bsg_manycore_request_initiator #(
      .x_cord_width_p(XW), .y_cord_width_p(YW), .addr_width_p(AW),
      .data_width_p(DW), .max_out_p(MO)
   ) dut (
      .clk_i(clk), .reset_i(reset_i),
      .cmd_v_i(cmd_v_i), .cmd_we_i(cmd_we_i), .cmd_addr_i(cmd_addr_i),
      .cmd_data_i(cmd_data_i), .cmd_mask_i(cmd_mask_i), .cmd_x_i(cmd_x_i), .cmd_y_i(cmd_y_i),
      .cmd_ready_o(cmd_ready_o), .out_v_o(out_v_o), .out_packet_o(out_packet_o),
      .out_ready_i(out_ready_i), .returned_v_i(returned_v_i), .returned_data_i(returned_data_i),
      .returned_reg_id_i(returned_reg_id_i), .returned_pkt_type_i(returned_pkt_type_i),
      .returned_yumi_o(returned_yumi_o), .returned_credit_v_i(returned_credit_v_i),
      .returned_credit_reg_id_i(returned_credit_reg_id_i), .resp_v_o(resp_v_o),
      .resp_data_o(resp_data_o), .resp_tag_o(resp_tag_o), .resp_yumi_i(resp_yumi_i),
      .fence_i(fence_i), .fence_done_o(fence_done_o), .outstanding_o(outstanding_o),
      .my_x_i(my_x_i), .my_y_i(my_y_i)
   );

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // Packet layout, MSB first: addr, op, op_ex, reg_id, payload, src_y, src_x, y, x.
   function automatic logic [PW-1:0] mk_pkt(input logic we, input logic [AW-1:0] addr,
         input logic [DW-1:0] data, input logic [MW-1:0] mask, input logic [XW-1:0] x,
         input logic [YW-1:0] y, input logic [4:0] tag);
      logic [1:0] op;
      op = we ? 2'd1 : 2'd0;
      return {addr, op, (we ? mask : 4'h0), tag, (we ? data : 32'h0), my_y_i, my_x_i, y, x};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
         input logic [MW-1:0] mask, input logic [XW-1:0] x, input logic [YW-1:0] y,
         input logic [4:0] tag);
      int n;
      n = 0;
      @(negedge clk);
      cmd_v_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_data_i = data;
      cmd_mask_i = mask; cmd_x_i = x; cmd_y_i = y;
      #3;
      while (!cmd_ready_o && n < 20) begin
         @(negedge clk); #3; n++;
      end
      if (n == 20) chk("issue_timeout", 0, 1);
      else pkt_q.push_back(mk_pkt(we, addr, data, mask, x, y, tag));
      @(posedge clk); #1;
      cmd_v_i = 1'b0;
   endtask

   task automatic credit(input logic [4:0] tag);
      @(negedge clk);
      returned_credit_v_i = 1'b1; returned_credit_reg_id_i = tag;
      @(negedge clk);
      returned_credit_v_i = 1'b0;
   endtask

   // Output monitor: sampled 1 ns before the rising edge.
   always @(negedge clk) begin
      logic [PW-1:0] ep;
      logic [36:0]   er;
      #4;
      if (!reset_i && out_v_o && out_ready_i) begin
         if (pkt_q.size() == 0) chk("pkt_unexpected", 1, 0);
         else begin ep = pkt_q.pop_front(); chk("pkt", out_packet_o, ep); end
      end
      if (!reset_i && resp_v_o && resp_yumi_i) begin
         if (resp_q.size() == 0) chk("resp_unexpected", 1, 0);
         else begin er = resp_q.pop_front(); chk("resp", {resp_tag_o, resp_data_o}, er); end
      end
   end

   initial begin
      logic [PW-1:0] held;
      idle(2);
      #3;
      chk("rst_out_v", out_v_o, 0);
      chk("rst_resp_v", resp_v_o, 0);
      chk("rst_outstanding", outstanding_o, 0);
      @(negedge clk); reset_i = 1'b0;
      #3;
      chk("idle_ready", cmd_ready_o, 1);
      chk("idle_fence_done", fence_done_o, 0);

      // 1: single load and its return
      issue(1'b0, 16'h0040, 32'h0, 4'h0, 4'd2, 4'd3, 5'd0);
      idle(2); #3;
      chk("t1_outstanding", outstanding_o, 1);
      @(negedge clk);
      returned_v_i = 1'b1; returned_data_i = 32'hDEADBEEF; returned_reg_id_i = 5'd0;
      resp_q.push_back({5'd0, 32'hDEADBEEF});
      #3 chk("t1_yumi", returned_yumi_o, 1);
      @(negedge clk); returned_v_i = 1'b0;
      #3 chk("t1_resp_v", resp_v_o, 1);
      idle(1); #3;
      chk("t1_outstanding_done", outstanding_o, 0);

      // 2: exhaust all tags, then free tag 5 and reuse it
      for (int i = 0; i < 8; i++)
         issue(1'b1, 16'h0200 + 16'(i), 32'h1000_0000 + 32'(i), 4'(i + 1), 4'd1, 4'd1, 5'(i));
      @(negedge clk); #3;
      chk("t2_full_ready", cmd_ready_o, 0);
      chk("t2_outstanding", outstanding_o, 8);
      @(negedge clk);
      returned_credit_v_i = 1'b1; returned_credit_reg_id_i = 5'd5;
      #3 chk("t2_ready_same_cycle", cmd_ready_o, 0);
      @(negedge clk); returned_credit_v_i = 1'b0;
      #3 chk("t2_ready_after_credit", cmd_ready_o, 1);
      issue(1'b1, 16'h0300, 32'hCAFE0005, 4'h3, 4'd6, 4'd7, 5'd5);
      for (int i = 0; i < 8; i++) credit(5'(i));
      idle(1); #3;
      chk("t2_outstanding_done", outstanding_o, 0);

      // 3: backpressure holds the packet stable and blocks new commands
      out_ready_i = 1'b0;
      issue(1'b1, 16'h0ABC, 32'h1234_5678, 4'h9, 4'd3, 4'd2, 5'd0);
      held = mk_pkt(1'b1, 16'h0ABC, 32'h1234_5678, 4'h9, 4'd3, 4'd2, 5'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #3;
         chk("t3_out_v", out_v_o, 1);
         chk("t3_stable", out_packet_o, held);
         chk("t3_ready_low", cmd_ready_o, 0);
      end
      @(negedge clk); out_ready_i = 1'b1;
      credit(5'd0);

      // 4: held response blocks a second return without losing it
      issue(1'b0, 16'h0100, 32'h0, 4'h0, 4'd2, 4'd3, 5'd0);
      issue(1'b0, 16'h0104, 32'h0, 4'h0, 4'd2, 4'd3, 5'd1);
      idle(2);
      @(negedge clk);
      resp_yumi_i = 1'b0;
      returned_v_i = 1'b1; returned_data_i = 32'h1111AAAA; returned_reg_id_i = 5'd0;
      resp_q.push_back({5'd0, 32'h1111AAAA});
      #3 chk("t4_yumi_first", returned_yumi_o, 1);
      @(negedge clk);
      returned_data_i = 32'h2222BBBB; returned_reg_id_i = 5'd1;
      #3 chk("t4_yumi_held", returned_yumi_o, 0);
      chk("t4_resp_v", resp_v_o, 1);
      @(negedge clk); #3;
      chk("t4_yumi_held2", returned_yumi_o, 0);
      chk("t4_resp_hold", {resp_tag_o, resp_data_o}, {5'd0, 32'h1111AAAA});
      resp_q.push_back({5'd1, 32'h2222BBBB});
      @(negedge clk); resp_yumi_i = 1'b1;
      #3 chk("t4_yumi_go", returned_yumi_o, 1);
      @(negedge clk); returned_v_i = 1'b0;
      idle(2); #3;
      chk("t4_resp_drained", resp_v_o, 0);
      chk("t4_outstanding", outstanding_o, 0);

      // 5: fence
      issue(1'b1, 16'h0010, 32'h1, 4'h1, 4'd1, 4'd0, 5'd0);
      issue(1'b1, 16'h0011, 32'h2, 4'h2, 4'd1, 4'd0, 5'd1);
      issue(1'b1, 16'h0012, 32'h3, 4'h4, 4'd1, 4'd0, 5'd2);
      idle(2);
      fence_i = 1'b1;
      #3;
      chk("t5_ready_fenced", cmd_ready_o, 0);
      chk("t5_fence_busy", fence_done_o, 0);
      credit(5'd0);
      credit(5'd1);
      @(negedge clk);
      returned_credit_v_i = 1'b1; returned_credit_reg_id_i = 5'd2;
      #3 chk("t5_fence_last_cycle", fence_done_o, 0);
      @(negedge clk); returned_credit_v_i = 1'b0;
      #3 chk("t5_fence_done", fence_done_o, 1);
      @(negedge clk); fence_i = 1'b0;

      // 6: asynchronous reset with loads in flight; return during reset is dropped
      for (int i = 0; i < 4; i++) issue(1'b0, 16'h0500 + 16'(i), 32'h0, 4'h0, 4'd2, 4'd2, 5'(i));
      idle(2); #3;
      chk("t6_outstanding", outstanding_o, 4);
      @(negedge clk); #2;
      reset_i = 1'b1;
      returned_v_i = 1'b1; returned_data_i = 32'hBAD0BAD0; returned_reg_id_i = 5'd2;
      #1;
      chk("t6_async_outstanding", outstanding_o, 0);
      chk("t6_async_out_v", out_v_o, 0);
      @(negedge clk); reset_i = 1'b0; returned_v_i = 1'b0;
      #3;
      chk("t6_no_resp", resp_v_o, 0);
      chk("t6_ready", cmd_ready_o, 1);
      idle(1); #3;
      chk("t6_no_resp_later", resp_v_o, 0);

      // 7: credit and load return on different tags in one cycle
      issue(1'b1, 16'h0700, 32'h7777, 4'hF, 4'd0, 4'd1, 5'd0);
      issue(1'b0, 16'h0704, 32'h0, 4'h0, 4'd0, 4'd1, 5'd1);
      idle(2);
      @(negedge clk);
      returned_credit_v_i = 1'b1; returned_credit_reg_id_i = 5'd0;
      returned_v_i = 1'b1; returned_data_i = 32'h0BADF00D; returned_reg_id_i = 5'd1;
      resp_q.push_back({5'd1, 32'h0BADF00D});
      @(negedge clk);
      returned_credit_v_i = 1'b0; returned_v_i = 1'b0;
      #3 chk("t7_both_clear", outstanding_o, 0);
      idle(2);

      chk("pkt_q_drained", 32'(pkt_q.size()), 0);
      chk("resp_q_drained", 32'(resp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
